// File: rtl/vector_packer_pkg.sv
// Shared constants for vector_packer: bank indices and the CLOG2 helper.
// Optional short-vector support is enabled with VECTOR_PACKER_LAST_EN.
`ifndef CLOG2
`define CLOG2(n) ($clog2(n))
`endif

package vector_packer_pkg;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  function automatic int cnt_width(input int dim);
    return `CLOG2(dim) + 1;
  endfunction

endpackage

// File: rtl/vector_packer_bank.sv
// One ping-pong bank: lane write decode into a registered DIM*W vector.
// A write to lane 0 clears the upper lanes, so short vectors are zero-filled.
module packer_bank #(
  parameter int DIM   = 8,
  parameter int W     = 64,
  parameter int CNT_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [CNT_W-1:0]   lane_i,
  input  logic [W-1:0]       data_i,
  output logic [DIM*W-1:0]   data_o
);

  logic [DIM*W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (we_i) begin
      for (int k = 0; k < DIM; k++) begin
        if (lane_i == CNT_W'(k)) begin
          data_d[W*k +: W] = data_i;
        end else if (lane_i == '0) begin
          data_d[W*k +: W] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/vector_packer.sv
// Serial-to-vector packer, double-buffered, valid/ready on both sides.
// Define VECTOR_PACKER_LAST_EN to add in_last / out_len short vectors.
module vector_packer
  import vector_packer_pkg::*;
#(
  parameter int DIM = 8,
  parameter int W   = 64,
  localparam int CNT_W = cnt_width(DIM)
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
`ifdef VECTOR_PACKER_LAST_EN
  input  logic               in_last,
  output logic [CNT_W-1:0]   out_len,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIM*W-1:0]   vector
);

  logic [1:0]       full_q, full_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic             in_fire, out_fire, last, done;
  logic [1:0]       we;
  logic [DIM*W-1:0] bank_data [2];

  assign in_ready  = !full_q[wr_ptr_q];
  assign out_valid = full_q[rd_ptr_q];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

`ifdef VECTOR_PACKER_LAST_EN
  assign last = in_last;
`else
  assign last = 1'b0;
`endif

  assign done = in_fire &&
                (last || fill_cnt_q == CNT_W'(DIM - 1));

  // Completion and drain always hit opposite banks.
  always_comb begin
    full_d     = full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_cnt_d = fill_cnt_q;
    if (out_fire) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = !rd_ptr_q;
    end
    if (in_fire) begin
      fill_cnt_d = fill_cnt_q + 1'b1;
    end
    if (done) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = !wr_ptr_q;
      fill_cnt_d       = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      full_q     <= '0;
      wr_ptr_q   <= BANK0;
      rd_ptr_q   <= BANK0;
      fill_cnt_q <= '0;
    end else begin
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  assign we[0] = in_fire && (wr_ptr_q == BANK0);
  assign we[1] = in_fire && (wr_ptr_q == BANK1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    packer_bank #(
      .DIM   (DIM),
      .W     (W),
      .CNT_W (CNT_W)
    ) u_bank (
      .clk_i  (Clock),
      .rst_ni (Reset_n),
      .we_i   (we[b]),
      .lane_i (fill_cnt_q),
      .data_i (in_data),
      .data_o (bank_data[b])
    );
  end

  assign vector = (rd_ptr_q == BANK1) ? bank_data[1] : bank_data[0];

`ifdef VECTOR_PACKER_LAST_EN
  logic [CNT_W-1:0] len_q [2];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      len_q[0] <= '0;
      len_q[1] <= '0;
    end else if (done) begin
      len_q[wr_ptr_q] <= fill_cnt_q + 1'b1;
    end
  end

  assign out_len = len_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_vector_packer.sv
// Randomized bench for vector_packer (DIM=4, W=8) against a queue model.
// Also exercises in_last/out_len when VECTOR_PACKER_LAST_EN is defined.
module tb_vector_packer;

  localparam int DIM = 4;
  localparam int W   = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DIM*W-1:0] vector;
`ifdef VECTOR_PACKER_LAST_EN
  logic             in_last = 1'b0;
  logic [CNT_W-1:0] out_len;
`endif

  int checks = 0;
  int failures = 0;

  logic [W-1:0]     part [$];
  logic [DIM*W-1:0] pend_v [$];
  int               pend_l [$];

  always #5 clk = ~clk;

  vector_packer #(.DIM(DIM), .W(W)) dut (
    .Clock     (clk),
    .Reset_n   (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef VECTOR_PACKER_LAST_EN
    .in_last   (in_last),
    .out_len   (out_len),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .vector    (vector)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    part.delete();
    pend_v.delete();
    pend_l.delete();
  endtask

  task automatic check_outputs();
    chk("in_ready", 64'(in_ready), 64'(pend_v.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(pend_v.size() > 0));
    if (pend_v.size() > 0) begin
      chk("vector", 64'(vector), 64'(pend_v[0]));
`ifdef VECTOR_PACKER_LAST_EN
      chk("out_len", 64'(out_len), 64'(pend_l[0]));
`endif
    end
  endtask

  // One clock: check, drive at negedge, advance the model at posedge.
  task automatic cycle(input bit v, input logic [W-1:0] d,
                       input bit l, input bit r, output bit acc);
    bit ofire;
    bit lst;
    logic [DIM*W-1:0] vec;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    in_data   = d;
    out_ready = r;
`ifdef VECTOR_PACKER_LAST_EN
    in_last = l;
    lst = l;
`else
    lst = 1'b0;
    if (l) lst = 1'b0;
`endif
    acc   = v && (pend_v.size() < 2);
    ofire = r && (pend_v.size() > 0);
    @(posedge clk);
    if (ofire) begin
      void'(pend_v.pop_front());
      void'(pend_l.pop_front());
    end
    if (acc) begin
      part.push_back(d);
      if (part.size() == DIM || lst) begin
        vec = '0;
        foreach (part[k]) vec |= (DIM*W)'(part[k]) << (W*k);
        pend_v.push_back(vec);
        pend_l.push_back(part.size());
        part.delete();
      end
    end
  endtask

  task automatic push(input logic [W-1:0] d, input bit r);
    bit a;
    cycle(1'b1, d, 1'b0, r, a);
  endtask

  task automatic idle(input int n, input bit r);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, r, a);
  endtask

  initial begin
    bit a;
    int idx;
    int budget;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_vector", 64'(vector), 64'd0);
    rst_n = 1'b1;

    // Basic back-to-back fill.
    for (int i = 1; i <= 4; i++) push(W'(i), 1'b1);
    idle(3, 1'b1);

    // Backpressure: 12 offered, two banks fill, then drain.
    idx = 1;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, W'(idx), 1'b0, 1'b0, a);
      if (a) idx++;
    end
    chk("bp_accepted", 64'(idx - 1), 64'd8);
    budget = 40;
    while (idx <= 12 && budget > 0) begin
      cycle(1'b1, W'(idx), 1'b0, 1'b1, a);
      if (a) idx++;
      budget--;
    end
    chk("bp_drain_timeout", 64'(idx), 64'd13);
    idle(4, 1'b1);

    // Simultaneous completion and drain.
    for (int i = 1; i <= 4; i++) push(W'(i), 1'b0);
    for (int i = 5; i <= 7; i++) push(W'(i), 1'b0);
    push(8'h08, 1'b1);
    idle(1, 1'b0);
    idle(3, 1'b1);

    // Input bubbles.
    push(8'h11, 1'b1);
    idle(3, 1'b1);
    push(8'h22, 1'b1);
    idle(1, 1'b1);
    push(8'h33, 1'b1);
    push(8'h44, 1'b1);
    idle(3, 1'b1);

    // Asynchronous reset with one held vector and a partial fill.
    for (int i = 1; i <= 4; i++) push(W'(i), 1'b0);
    push(8'hAA, 1'b0);
    push(8'hBB, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    model_clear();
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) push(W'(i), 1'b1);
    idle(3, 1'b1);

`ifdef VECTOR_PACKER_LAST_EN
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, a);
    cycle(1'b1, 8'hBB, 1'b1, 1'b0, a);
    for (int i = 1; i <= 4; i++) push(W'(i), 1'b0);
    idle(4, 1'b1);
`endif

    // Random traffic with bursty backpressure.
    for (int c = 0; c < 3000; c++) begin
      bit v, r, l;
      v = ($urandom_range(0, 3) != 0);
      r = ((c / 50) % 3 == 1) ? ($urandom_range(0, 7) == 0)
                               : ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 7) == 0);
      cycle(v, W'($urandom), l, r, a);
    end
    idle(6, 1'b1);
    @(negedge clk);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
